// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM encoding, default sizing
// and the word-index width helper used by the responder and its storage.
package mem_responder_pkg;

    localparam int WORD_WIDTH          = 32;
    localparam int DEFAULT_DEPTH_WORDS = 256;
    localparam int DEFAULT_WAIT_CYCLES = 2;
    localparam int WAIT_CNT_WIDTH      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic int word_index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word storage for the responder: synchronous write, combinational read,
// whole array cleared by the asynchronous active-low reset.
module mem_word_array
    import mem_responder_pkg::*;
#(
    parameter  int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    localparam int IDX_W       = word_index_width(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [WORD_WIDTH-1:0] rd_data
);

    logic [WORD_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one word request, inserts
// WAIT_CYCLES wait states, then returns a one-cycle response with error flag.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           address,
    input  logic [WORD_WIDTH-1:0] write_data,
    output logic                  resp_valid,
    output logic [WORD_WIDTH-1:0] read_data,
    output logic                  err
);

    localparam int IDX_W = word_index_width(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_WIDTH'(WAIT_CYCLES - 1) : '0;

    state_t state, next_state;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt, next_wait_cnt;

    logic [31:0]           lat_address;
    logic [WORD_WIDTH-1:0] lat_write_data;
    logic                  lat_read;
    logic                  lat_write;

    logic [31:0]           cur_address;
    logic [WORD_WIDTH-1:0] cur_write_data;
    logic                  cur_read;
    logic                  cur_write;
    logic                  req_err;
    logic                  enter_resp;
    logic                  accept;
    logic                  mem_wr_en;
    logic [IDX_W-1:0]      word_idx;
    logic [WORD_WIDTH-1:0] rd_word;

    logic                  resp_err_q;
    logic [WORD_WIDTH-1:0] resp_data_q;

    assign accept = req_valid && (state == ST_IDLE);

    // With zero wait states RESP is entered on the accept edge itself, so the
    // live inputs stand in for the latched request while still in IDLE.
    assign cur_address    = (state == ST_IDLE) ? address    : lat_address;
    assign cur_write_data = (state == ST_IDLE) ? write_data : lat_write_data;
    assign cur_read       = (state == ST_IDLE) ? mem_read   : lat_read;
    assign cur_write      = (state == ST_IDLE) ? mem_write  : lat_write;

    assign req_err = (cur_address[1:0] != 2'b00) ||
                     (cur_address[31:2] >= DEPTH_LIMIT) ||
                     (cur_read == cur_write);

    assign word_idx   = cur_address[IDX_W+1:2];
    assign enter_resp = (next_state == ST_RESP) && (state != ST_RESP);
    assign mem_wr_en  = enter_resp && !req_err && cur_write;

    mem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (mem_wr_en),
        .wr_idx (word_idx),
        .wr_data(cur_write_data),
        .rd_idx (word_idx),
        .rd_data(rd_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait_cnt;
        end
    end

    always_comb begin
        next_state    = state;
        next_wait_cnt = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        next_state = ST_RESP;
                    end else begin
                        next_state    = ST_WAIT;
                        next_wait_cnt = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    next_state = ST_RESP;
                end else begin
                    next_wait_cnt = wait_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state    = ST_IDLE;
                next_wait_cnt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_address    <= '0;
            lat_write_data <= '0;
            lat_read       <= 1'b0;
            lat_write      <= 1'b0;
        end else if (accept) begin
            lat_address    <= address;
            lat_write_data <= write_data;
            lat_read       <= mem_read;
            lat_write      <= mem_write;
        end
    end

    // Read data is captured on the edge entering RESP, before any later write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_err_q  <= 1'b0;
            resp_data_q <= '0;
        end else if (enter_resp) begin
            resp_err_q  <= req_err;
            resp_data_q <= (req_err || !cur_read) ? '0 : rd_word;
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign err        = resp_valid && resp_err_q;
    assign read_data  = resp_valid ? resp_data_q : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a default instance checked against a
// reference memory model, plus a zero-wait-state instance checked inline.
module tb_mem_responder;

    localparam int DEPTH  = 256;
    localparam int WAITC  = 2;
    localparam int DEPTH0 = 16;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;

    logic        req_valid  = 1'b0;
    logic        mem_read   = 1'b0;
    logic        mem_write  = 1'b0;
    logic [31:0] address    = '0;
    logic [31:0] write_data = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        err;

    logic        z0_req_valid  = 1'b0;
    logic        z0_mem_read   = 1'b0;
    logic        z0_mem_write  = 1'b0;
    logic [31:0] z0_address    = '0;
    logic [31:0] z0_write_data = '0;
    logic        z0_req_ready;
    logic        z0_resp_valid;
    logic [31:0] z0_read_data;
    logic        z0_err;

    int          n_checks   = 0;
    int          n_pass     = 0;
    int          cyc        = 0;
    int          resp_count = 0;
    int          resp_cycles[$];
    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(WAITC)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .address   (address),
        .write_data(write_data),
        .resp_valid(resp_valid),
        .read_data (read_data),
        .err       (err)
    );

    mem_responder #(
        .DEPTH_WORDS(DEPTH0),
        .WAIT_CYCLES(0)
    ) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (z0_req_valid),
        .req_ready (z0_req_ready),
        .mem_read  (z0_mem_read),
        .mem_write (z0_mem_write),
        .address   (z0_address),
        .write_data(z0_write_data),
        .resp_valid(z0_resp_valid),
        .read_data (z0_read_data),
        .err       (z0_err)
    );

    function automatic exp_t model_request(input logic rd, input logic wr,
                                           input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.err  = (a[1:0] != 2'b00) || (a[31:2] >= DEPTH) || (rd == wr);
        e.data = '0;
        if (!e.err) begin
            if (wr) model_mem[a[9:2]] = d;
            else    e.data = model_mem[a[9:2]];
        end
        return e;
    endfunction

    // Responses are popped from the scoreboard as they appear.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid === 1'b1) begin
            resp_count++;
            resp_cycles.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL resp_unexpected: resp_valid=1 at cycle %0d, none outstanding", cyc);
            end else begin
                n_pass++;
                e = exp_q.pop_front();
                n_checks++;
                if (err !== e.err)
                    $display("[TB] FAIL resp_err: got %b want %b (cycle %0d)", err, e.err, cyc);
                else n_pass++;
                n_checks++;
                if (read_data !== e.data)
                    $display("[TB] FAIL resp_data: got %h want %h (cycle %0d)", read_data, e.data, cyc);
                else n_pass++;
            end
        end else begin
            n_checks++;
            if (err !== 1'b0 || read_data !== 32'h0 || resp_valid !== 1'b0)
                $display("[TB] FAIL idle_outputs: got err=%b data=%h valid=%b want 0/0/0",
                         err, read_data, resp_valid);
            else n_pass++;
        end
    end

    task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] a,
                                  input logic [31:0] d, input logic hold,
                                  output int acc_cyc, output int waited);
        mem_read   = rd;
        mem_write  = wr;
        address    = a;
        write_data = d;
        req_valid  = 1'b1;
        waited     = 0;
        acc_cyc    = -1;
        #1;
        while (req_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (req_ready !== 1'b1) begin
            n_checks++;
            $display("[TB] FAIL accept_timeout: req_ready=%b want 1 within 50 cycles", req_ready);
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back(model_request(rd, wr, a, d));
        @(negedge clk);
        acc_cyc = cyc;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || resp_valid === 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("[TB] FAIL drain_timeout: %0d responses outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || err !== 1'b0 || read_data !== 32'h0)
            $display("[TB] FAIL reset_during: ready=%b valid=%b err=%b data=%h want 1/0/0/0",
                     req_ready, resp_valid, err, read_data);
        else n_pass++;
        foreach (model_mem[i]) model_mem[i] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || err !== 1'b0 || read_data !== 32'h0)
            $display("[TB] FAIL reset_after: ready=%b valid=%b err=%b data=%h want 1/0/0/0",
                     req_ready, resp_valid, err, read_data);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int acc, w;
        apply_stimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, acc, w);
        wait_drain();
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, acc, w);
        wait_drain();
        n_checks++;
        if (resp_cycles.size() == 0 || resp_cycles[$] - acc !== WAITC)
            $display("[TB] FAIL read_latency: got %0d edges want %0d",
                     (resp_cycles.size() == 0) ? -1 : resp_cycles[$] - acc, WAITC);
        else n_pass++;
        apply_stimulus(1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, acc, w);
        apply_stimulus(1'b0, 1'b1, 32'h3FC, 32'hA5A5_0F0F, 1'b0, acc, w);
        apply_stimulus(1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, acc, w);
        wait_drain();
    endtask

    task automatic test_errors();
        int acc, w, rc0;
        rc0 = resp_count;
        apply_stimulus(1'b1, 1'b0, 32'h12,  32'h0,        1'b0, acc, w);
        apply_stimulus(1'b1, 1'b0, 32'h400, 32'h0,        1'b0, acc, w);
        apply_stimulus(1'b1, 1'b1, 32'h20,  32'h1234,     1'b0, acc, w);
        apply_stimulus(1'b0, 1'b0, 32'h24,  32'h5678,     1'b0, acc, w);
        apply_stimulus(1'b0, 1'b1, 32'h400, 32'h1111_2222, 1'b0, acc, w);
        apply_stimulus(1'b0, 1'b1, 32'h13,  32'h3333_4444, 1'b0, acc, w);
        apply_stimulus(1'b1, 1'b0, 32'h20,  32'h0,        1'b0, acc, w);
        apply_stimulus(1'b1, 1'b0, 32'h0,   32'h0,        1'b0, acc, w);
        apply_stimulus(1'b1, 1'b0, 32'h10,  32'h0,        1'b0, acc, w);
        wait_drain();
        n_checks++;
        if (resp_count - rc0 !== 9)
            $display("[TB] FAIL error_resp_count: got %0d want 9", resp_count - rc0);
        else n_pass++;
    endtask

    task automatic test_drop_valid();
        int acc, w, rc0;
        rc0 = resp_count;
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, acc, w);
        mem_read   = 1'b0;
        mem_write  = 1'b1;
        address    = 32'h10;
        write_data = 32'hBAD0_BAD0;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, acc, w);
        wait_drain();
        n_checks++;
        if (resp_count - rc0 !== 2)
            $display("[TB] FAIL drop_valid_count: got %0d want 2", resp_count - rc0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc[4];
        int w[4];
        int rc0, nr;
        logic [31:0] addrs[4] = '{32'h80, 32'h80, 32'h84, 32'h84};
        logic [31:0] datas[4] = '{32'h0BAD_F00D, 32'h0, 32'h7777_8888, 32'h0};
        rc0 = resp_count;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(i[0], ~i[0], addrs[i], datas[i], 1'b1, acc[i], w[i]);
        end
        req_valid = 1'b0;
        wait_drain();
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (acc[i] - acc[i-1] !== WAITC + 2)
                $display("[TB] FAIL b2b_accept_spacing[%0d]: got %0d want %0d", i, acc[i] - acc[i-1], WAITC + 2);
            else n_pass++;
            n_checks++;
            if (w[i] !== WAITC + 1)
                $display("[TB] FAIL b2b_ready_low[%0d]: got %0d cycles want %0d", i, w[i], WAITC + 1);
            else n_pass++;
        end
        nr = resp_count - rc0;
        n_checks++;
        if (nr !== 4) $display("[TB] FAIL b2b_resp_count: got %0d want 4", nr);
        else n_pass++;
        if (nr == 4) begin
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (resp_cycles[rc0+i] - resp_cycles[rc0+i-1] !== WAITC + 2)
                    $display("[TB] FAIL b2b_resp_spacing[%0d]: got %0d want %0d", i,
                             resp_cycles[rc0+i] - resp_cycles[rc0+i-1], WAITC + 2);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_abort();
        int acc, w, rc0;
        apply_stimulus(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 1'b0, acc, w);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("[TB] FAIL abort_async: ready=%b valid=%b want 1/0", req_ready, resp_valid);
        else n_pass++;
        exp_q.delete();
        foreach (model_mem[i]) model_mem[i] = '0;
        rc0 = resp_count;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        apply_stimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, acc, w);
        n_checks++;
        if (w !== 0) $display("[TB] FAIL abort_first_accept: waited %0d cycles want 0", w);
        else n_pass++;
        wait_drain();
        n_checks++;
        if (resp_count - rc0 !== 1)
            $display("[TB] FAIL abort_resp_count: got %0d want 1", resp_count - rc0);
        else n_pass++;
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, acc, w);
        wait_drain();
    endtask

    task automatic test_zero_wait();
        z0_mem_read   = 1'b0;
        z0_mem_write  = 1'b1;
        z0_address    = 32'h8;
        z0_write_data = 32'h0000_55AA;
        z0_req_valid  = 1'b1;
        #1;
        n_checks++;
        if (z0_req_ready !== 1'b1) $display("[TB] FAIL z0_ready_idle: got %b want 1", z0_req_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (z0_resp_valid !== 1'b1 || z0_err !== 1'b0 || z0_read_data !== 32'h0 || z0_req_ready !== 1'b0)
            $display("[TB] FAIL z0_write_resp: valid=%b err=%b data=%h ready=%b want 1/0/0/0",
                     z0_resp_valid, z0_err, z0_read_data, z0_req_ready);
        else n_pass++;
        z0_mem_read  = 1'b1;
        z0_mem_write = 1'b0;
        @(negedge clk);
        n_checks++;
        if (z0_resp_valid !== 1'b0 || z0_req_ready !== 1'b1)
            $display("[TB] FAIL z0_gap: valid=%b ready=%b want 0/1", z0_resp_valid, z0_req_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (z0_resp_valid !== 1'b1 || z0_err !== 1'b0 || z0_read_data !== 32'h0000_55AA)
            $display("[TB] FAIL z0_read_resp: valid=%b err=%b data=%h want 1/0/000055aa",
                     z0_resp_valid, z0_err, z0_read_data);
        else n_pass++;
        z0_address = 32'h40;
        repeat (2) @(negedge clk);
        n_checks++;
        if (z0_resp_valid !== 1'b1 || z0_err !== 1'b1 || z0_read_data !== 32'h0)
            $display("[TB] FAIL z0_range_err: valid=%b err=%b data=%h want 1/1/0",
                     z0_resp_valid, z0_err, z0_read_data);
        else n_pass++;
        z0_req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] mem_responder bench start");
        test_reset();
        test_write_read();
        test_errors();
        test_drop_valid();
        test_back_to_back();
        test_reset_abort();
        test_zero_wait();
        n_checks++;
        if (exp_q.size() !== 0) $display("[TB] FAIL scoreboard_empty: got %0d want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
